ex_muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide unit in the EX stage, directly downstream of the ALU-control decode. It receives the decoded M-extension operation and the forwarded operands. It produces a registered result and a stall request that freezes IF/ID/EX until the result is ready. Single-cycle ALU ops bypass this block entirely.

---
 rtl/ex_muldiv_unit_pkg.sv | 27 ++
 rtl/ex_muldiv_unit_if.sv | 27 ++
 rtl/muldiv_divider.sv | 68 ++++++
 rtl/ex_muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: operation codes,
// FSM states and the ALU-control selector that routes work to this block.
package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  // ALUcntrl/ALUOp value that steers an instruction into the multi-cycle unit.
  localparam logic [3:0] ALU_MULDIV = 4'b1010;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline and the mul/div unit.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  import ex_muldiv_unit_pkg::*;

  logic            start;
  md_op_e          md_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output start, md_op, op_a, op_b, flush,
    input  stall, done, result, busy
  );

  modport slave (
    input  start, md_op, op_a, op_b, flush,
    output stall, done, result, busy
  );

endinterface

// File: rtl/muldiv_divider.sv
// Restoring divider on operand magnitudes: one shift/subtract per step,
// iteration counter, and sign fixup of quotient and remainder.
module muldiv_divider #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_last,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem
);

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_rq;
  logic [XLEN-1:0]   r_div;
  logic              r_neg_q;
  logic              r_neg_r;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_hi;
  logic [XLEN:0]     w_trial;

  assign w_a_neg = i_signed & i_a[XLEN-1];
  assign w_b_neg = i_signed & i_b[XLEN-1];
  assign w_a_mag = w_a_neg ? ({XLEN{1'b0}} - i_a) : i_a;
  assign w_b_mag = w_b_neg ? ({XLEN{1'b0}} - i_b) : i_b;

  // Partial remainder shifted left with the next dividend bit, then trial-subtracted.
  assign w_hi    = r_rq[2*XLEN-1:XLEN-1];
  assign w_trial = w_hi - {1'b0, r_div};

  assign o_last = (r_cnt == CNT_W'(1));
  assign o_quot = r_neg_q ? ({XLEN{1'b0}} - r_rq[XLEN-1:0]) : r_rq[XLEN-1:0];
  assign o_rem  = r_neg_r ? ({XLEN{1'b0}} - r_rq[2*XLEN-1:XLEN]) : r_rq[2*XLEN-1:XLEN];

  // Load magnitudes and signs on accept, then one restoring step per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= {CNT_W{1'b0}};
      r_rq    <= {(2*XLEN){1'b0}};
      r_div   <= {XLEN{1'b0}};
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= CNT_W'(DIV_CYCLES);
      r_rq    <= {{XLEN{1'b0}}, w_a_mag};
      r_div   <= w_b_mag;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end else if (i_step) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_rq  <= w_trial[XLEN] ? {w_hi[XLEN-1:0], r_rq[XLEN-2:0], 1'b0}
                             : {w_trial[XLEN-1:0], r_rq[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage: pipelined product,
// restoring divider, registered result with a one-cycle done pulse.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input logic              clock,
  input logic              reset,
  ex_muldiv_unit_if.slave  bus
);

  localparam int MUL_STG = (MUL_CYCLES > 1) ? (MUL_CYCLES - 1) : 1;

  md_state_e         r_state;
  md_op_e            r_op;
  logic [XLEN-1:0]   r_result;
  logic              r_done;
  logic [2:0]        r_mul_cnt;
  logic [2*XLEN-1:0] r_ma;
  logic [2*XLEN-1:0] r_mb;
  logic [2*XLEN-1:0] r_prod [MUL_STG];

  logic              w_accept;
  logic              w_is_div;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_special;
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic              w_div_last;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_div_res;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_mul_out;

  assign w_accept  = (r_state == ST_IDLE) & bus.start & ~bus.flush;
  assign w_is_div  = bus.md_op[2];
  assign w_b_zero  = (bus.op_b == {XLEN{1'b0}});
  assign w_ovf     = ~bus.md_op[0] & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
                     & (bus.op_b == {XLEN{1'b1}});
  assign w_special = w_is_div & (w_b_zero | w_ovf);
  assign w_a_sgn   = ((bus.md_op == MD_MULH) | (bus.md_op == MD_MULHSU)) & bus.op_a[XLEN-1];
  assign w_b_sgn   = (bus.md_op == MD_MULH) & bus.op_b[XLEN-1];

  // Divide-by-zero and signed overflow resolve at accept without iterating.
  always_comb begin
    w_special_res = {XLEN{1'b0}};
    if (bus.md_op[1]) begin
      w_special_res = w_b_zero ? bus.op_a : {XLEN{1'b0}};
    end else begin
      w_special_res = w_b_zero ? {XLEN{1'b1}} : bus.op_a;
    end
  end

  // Operands are pre-extended to 2*XLEN, so the low 2*XLEN bits are exact for every sign mix.
  assign w_prod    = r_ma * r_mb;
  assign w_mul_out = (MUL_CYCLES > 1) ? r_prod[MUL_STG-1] : w_prod;
  assign w_div_res = r_op[1] ? w_rem : w_quot;

  // Product pipeline feeding the MUL->DONE transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MUL_STG; i++) r_prod[i] <= {(2*XLEN){1'b0}};
    end else begin
      r_prod[0] <= w_prod;
      for (int i = 1; i < MUL_STG; i++) r_prod[i] <= r_prod[i-1];
    end
  end

  muldiv_divider #(
    .XLEN       (XLEN),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_divider (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_accept & w_is_div & ~w_special),
    .i_step   (r_state == ST_DIV),
    .i_signed (~bus.md_op[0]),
    .i_a      (bus.op_a),
    .i_b      (bus.op_b),
    .o_last   (w_div_last),
    .o_quot   (w_quot),
    .o_rem    (w_rem)
  );

  // Control FSM; flush wins over start and over the DONE transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= MD_MUL;
      r_result  <= {XLEN{1'b0}};
      r_done    <= 1'b0;
      r_mul_cnt <= 3'd0;
      r_ma      <= {(2*XLEN){1'b0}};
      r_mb      <= {(2*XLEN){1'b0}};
    end else if (bus.flush) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op      <= bus.md_op;
            r_mul_cnt <= 3'd0;
            r_ma      <= {{XLEN{w_a_sgn}}, bus.op_a};
            r_mb      <= {{XLEN{w_b_sgn}}, bus.op_b};
            if (!w_is_div) begin
              r_state <= ST_MUL;
            end else if (w_special) begin
              r_state  <= ST_DONE;
              r_result <= w_special_res;
              r_done   <= 1'b1;
            end else begin
              r_state <= ST_DIV;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (r_mul_cnt == 3'(MUL_CYCLES - 1)) begin
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_result <= (r_op == MD_MUL) ? w_mul_out[XLEN-1:0] : w_mul_out[2*XLEN-1:XLEN];
          end else begin
            r_mul_cnt <= r_mul_cnt + 3'd1;
          end
        end
        ST_DIV: begin
          r_state <= w_div_last ? ST_FIX : ST_DIV;
        end
        ST_FIX: begin
          r_state  <= ST_DONE;
          r_done   <= 1'b1;
          r_result <= w_div_res;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall  = w_accept | (r_state == ST_MUL) | (r_state == ST_DIV) | (r_state == ST_FIX);
  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: latency, values, special
// cases, flush, mid-operation reset and back-to-back starts.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  ex_muldiv_unit_if #(.XLEN(32)) bus();

  ex_muldiv_unit #(
    .XLEN       (32),
    .MUL_CYCLES (2),
    .DIV_CYCLES (32)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Called just after a negedge (cycle 0). Operands are corrupted from cycle 1 on.
  task automatic issue_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          output int done_cyc, output logic [31:0] res, output int stall_bad);
    bus.start = 1'b1; bus.md_op = op; bus.op_a = a; bus.op_b = b;
    #1;
    stall_bad = (bus.stall === 1'b1) ? 0 : 1;
    done_cyc  = -1;
    res       = 32'h0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      bus.start = 1'b0; bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'h0;
      #1;
      if (bus.done === 1'b1) begin
        done_cyc = c;
        res      = bus.result;
        if (bus.stall !== 1'b0) stall_bad++;
        break;
      end else if (bus.stall !== 1'b1) begin
        stall_bad++;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.md_op = MD_MUL; bus.op_a = 32'h0; bus.op_b = 32'h0; bus.flush = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    n_tests++; if (bus.done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_tests++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.stall !== 1'b0)      begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    n_tests++; if (bus.result !== 32'h0)    begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
  endtask

  task automatic test_mul();
    int dc, sb;
    logic [31:0] r;
    md_op_e      t_op  [3] = '{MD_MULHU, MD_MULH, MD_MULHSU};
    logic [31:0] t_exp [3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    @(negedge clock);
    issue_op(MD_MUL, 32'h0000_0007, 32'hFFFF_FFFD, dc, r, sb);
    n_tests++; if (dc !== 3)            begin n_fail++; $display("FAIL mul_latency: got %0d want 3", dc); end
    n_tests++; if (r !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_value: got %h want ffffffeb", r); end
    n_tests++; if (sb !== 0)            begin n_fail++; $display("FAIL mul_stall: %0d bad stall cycles, want 0", sb); end
    @(negedge clock); #1;
    n_tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL mul_after_done: done=%b busy=%b want 0 0", bus.done, bus.busy); end
    n_tests++; if (bus.result !== 32'hFFFF_FFEB)
      begin n_fail++; $display("FAIL mul_result_hold: got %h want ffffffeb", bus.result); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      issue_op(t_op[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, r, sb);
      n_tests++; if (dc !== 3 || r !== t_exp[i] || sb !== 0)
        begin n_fail++; $display("FAIL mulh_%0d: cyc=%0d res=%h stallbad=%0d want cyc=3 res=%h", i, dc, r, sb, t_exp[i]); end
    end
  endtask

  task automatic test_div();
    int dc, sb;
    logic [31:0] r;
    md_op_e      t_op  [4] = '{MD_DIV, MD_REM, MD_DIVU, MD_REMU};
    logic [31:0] t_a   [4] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100};
    logic [31:0] t_b   [4] = '{32'd3, 32'd3, 32'd7, 32'd7};
    logic [31:0] t_exp [4] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      issue_op(t_op[i], t_a[i], t_b[i], dc, r, sb);
      n_tests++; if (dc !== 34 || r !== t_exp[i] || sb !== 0)
        begin n_fail++; $display("FAIL div_%0d: cyc=%0d res=%h stallbad=%0d want cyc=34 res=%h", i, dc, r, sb, t_exp[i]); end
    end
  endtask

  task automatic test_special();
    int dc, sb;
    logic [31:0] r;
    md_op_e      t_op  [5] = '{MD_DIVU, MD_REM, MD_DIV, MD_REM, MD_DIV};
    logic [31:0] t_a   [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] t_b   [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] t_exp [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      issue_op(t_op[i], t_a[i], t_b[i], dc, r, sb);
      n_tests++; if (dc !== 1 || r !== t_exp[i] || sb !== 0)
        begin n_fail++; $display("FAIL special_%0d: cyc=%0d res=%h stallbad=%0d want cyc=1 res=%h", i, dc, r, sb, t_exp[i]); end
    end
  endtask

  task automatic test_flush();
    int dc, sb;
    logic [31:0] r;
    logic saw_done;
    @(negedge clock);
    issue_op(MD_MUL, 32'd6, 32'd7, dc, r, sb);
    n_tests++; if (r !== 32'd42) begin n_fail++; $display("FAIL flush_pre: got %h want 2a", r); end
    @(negedge clock);
    bus.start = 1'b1; bus.md_op = MD_DIV; bus.op_a = 32'd100; bus.op_b = 32'd7;
    saw_done = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clock);
      bus.start = 1'b0;
      bus.flush = (c == 10);
      #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    n_tests++; if (bus.busy !== 1'b0)   begin n_fail++; $display("FAIL flush_idle: busy=%b want 0", bus.busy); end
    n_tests++; if (saw_done !== 1'b0)   begin n_fail++; $display("FAIL flush_no_done: saw done=%b want 0", saw_done); end
    n_tests++; if (bus.result !== 32'd42) begin n_fail++; $display("FAIL flush_result: got %h want 2a", bus.result); end
    issue_op(MD_MUL, 32'd3, 32'd5, dc, r, sb);
    n_tests++; if (dc !== 3 || r !== 32'd15)
      begin n_fail++; $display("FAIL flush_restart: cyc=%0d res=%h want cyc=3 res=f", dc, r); end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    bus.start = 1'b1; bus.md_op = MD_DIV; bus.op_a = 32'd100; bus.op_b = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (c == 5) reset = 1'b1;
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_tests++; if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0)
      begin n_fail++; $display("FAIL reset_mid_ctrl: busy=%b stall=%b done=%b want 0 0 0", bus.busy, bus.stall, bus.done); end
    n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_mid_result: got %h want 0", bus.result); end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int first_cyc = -1;
    int second_cyc = -1;
    logic [31:0] first_res = 32'h0;
    logic [31:0] second_res = 32'h0;
    logic stall3 = 1'b1;
    logic stall4 = 1'b0;
    @(negedge clock);
    bus.start = 1'b1; bus.md_op = MD_MUL; bus.op_a = 32'd2; bus.op_b = 32'd3;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 1) begin bus.op_a = 32'd4; bus.op_b = 32'd5; end
      if (c == 5) bus.start = 1'b0;
      #1;
      if (c == 3) stall3 = bus.stall;
      if (c == 4) stall4 = bus.stall;
      if (bus.done === 1'b1) begin
        n_done++;
        if (n_done == 1) begin first_cyc = c; first_res = bus.result; end
        else if (n_done == 2) begin second_cyc = c; second_res = bus.result; end
      end
    end
    n_tests++; if (n_done !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d done pulses want 2", n_done); end
    n_tests++; if (first_cyc !== 3 || first_res !== 32'd6)
      begin n_fail++; $display("FAIL b2b_first: cyc=%0d res=%h want cyc=3 res=6", first_cyc, first_res); end
    n_tests++; if (second_cyc !== 7 || second_res !== 32'd20)
      begin n_fail++; $display("FAIL b2b_second: cyc=%0d res=%h want cyc=7 res=14", second_cyc, second_res); end
    n_tests++; if (stall3 !== 1'b0 || stall4 !== 1'b1)
      begin n_fail++; $display("FAIL b2b_stall: done-cycle=%b idle-cycle=%b want 0 1", stall3, stall4); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
